// File: rtl/idex_stage.sv
// ----------------------------------------------------------------------------
// idex_stage
//   ID/EX pipeline register for the 16-register, 16-bit pipelined core.
//   Each cycle it captures the decoded operands and control from ID. It
//   inserts a bubble on a load-use hazard or a branch flush, and freezes
//   while data memory holds the pipe. Register-file read data is bypassed
//   from the write-back stage so a same-cycle WB write is not missed.
//
//   Ports
//     clk, rst            clock (rising edge), async active-high reset
//     IFID*               decoded instruction fields from the IF/ID register
//     MEMWBregWrite/rd/data  write-back port, used for the WB bypass
//     flush               taken branch/jump resolved in EX -> bubble
//     memHold             data memory busy -> whole stage frozen
//     IDEX*               registered fields driving EX and forwarding
//     stallIF             combinational; hold PC and IF/ID this cycle
//     stallCnt            saturating count of load-use bubbles inserted
//
//   Handshake: there is no valid/ready pair. IDEXvalid qualifies the
//   registered instruction. stallIF is the only back-pressure signal: while
//   it is high, IF/ID must present the same instruction again next cycle.
// ----------------------------------------------------------------------------
module idex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  IFIDrs,
    input  logic [REG_W-1:0]  IFIDrt,
    input  logic [REG_W-1:0]  IFIDrd,
    input  logic              IFIDusesRt,
    input  logic [DATA_W-1:0] IFIDrdata1,
    input  logic [DATA_W-1:0] IFIDrdata2,
    input  logic [DATA_W-1:0] IFIDimm,
    input  logic              IFIDregWrite,
    input  logic              IFIDmemRead,
    input  logic              IFIDmemWrite,
    input  logic              IFIDaluSrc,
    input  logic [3:0]        IFIDaluOp,
    input  logic              IFIDvalid,
    input  logic              MEMWBregWrite,
    input  logic [REG_W-1:0]  MEMWBrd,
    input  logic [DATA_W-1:0] MEMWBdata,
    input  logic              flush,
    input  logic              memHold,
    output logic [REG_W-1:0]  IDEXrs,
    output logic [REG_W-1:0]  IDEXrt,
    output logic [REG_W-1:0]  IDEXrd,
    output logic [DATA_W-1:0] IDEXrdata1,
    output logic [DATA_W-1:0] IDEXrdata2,
    output logic [DATA_W-1:0] IDEXimm,
    output logic              IDEXregWrite,
    output logic              IDEXmemRead,
    output logic              IDEXmemWrite,
    output logic              IDEXaluSrc,
    output logic              IDEXvalid,
    output logic [3:0]        IDEXaluOp,
    output logic              stallIF,
    output logic [CNT_W-1:0]  stallCnt
);

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic [3:0]        alu_op;
        logic              valid;
    } idex_t;

    // Per-cycle decision, highest priority first.
    typedef enum logic [1:0] {
        ACT_RUN   = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_HOLD  = 2'd3
    } action_t;

    idex_t            idex_q, idex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    action_t          action;
    logic             lu_haz;
    logic             byp1, byp2;

    // The load in EX writes rt. Register 0 never carries a dependency.
    always_comb begin
        lu_haz = idex_q.valid & idex_q.mem_read & (idex_q.rt != '0) & IFIDvalid &
                 ((idex_q.rt == IFIDrs) | (IFIDusesRt & (idex_q.rt == IFIDrt)));
        byp1   = MEMWBregWrite & (MEMWBrd != '0) & (MEMWBrd == IFIDrs);
        byp2   = MEMWBregWrite & (MEMWBrd != '0) & (MEMWBrd == IFIDrt);

        if (memHold)     action = ACT_HOLD;
        else if (flush)  action = ACT_FLUSH;
        else if (lu_haz) action = ACT_STALL;
        else             action = ACT_RUN;

        stallIF = (action == ACT_HOLD) | (action == ACT_STALL);
    end

    always_comb begin
        idex_d = idex_q;
        cnt_d  = cnt_q;
        case (action)
            ACT_HOLD: begin
                idex_d = idex_q;
            end
            ACT_FLUSH: begin
                idex_d = '0;
            end
            ACT_STALL: begin
                idex_d = '0;
                if (cnt_q != '1) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            ACT_RUN: begin
                // Fields load unmasked even when IFIDvalid=0; EX ignores them.
                idex_d.rs        = IFIDrs;
                idex_d.rt        = IFIDrt;
                idex_d.rd        = IFIDrd;
                idex_d.rdata1    = byp1 ? MEMWBdata : IFIDrdata1;
                idex_d.rdata2    = byp2 ? MEMWBdata : IFIDrdata2;
                idex_d.imm       = IFIDimm;
                idex_d.reg_write = IFIDregWrite;
                idex_d.mem_read  = IFIDmemRead;
                idex_d.mem_write = IFIDmemWrite;
                idex_d.alu_src   = IFIDaluSrc;
                idex_d.alu_op    = IFIDaluOp;
                idex_d.valid     = IFIDvalid;
            end
            default: begin
                idex_d = idex_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
            cnt_q  <= '0;
        end else begin
            idex_q <= idex_d;
            cnt_q  <= cnt_d;
        end
    end

    assign IDEXrs       = idex_q.rs;
    assign IDEXrt       = idex_q.rt;
    assign IDEXrd       = idex_q.rd;
    assign IDEXrdata1   = idex_q.rdata1;
    assign IDEXrdata2   = idex_q.rdata2;
    assign IDEXimm      = idex_q.imm;
    assign IDEXregWrite = idex_q.reg_write;
    assign IDEXmemRead  = idex_q.mem_read;
    assign IDEXmemWrite = idex_q.mem_write;
    assign IDEXaluSrc   = idex_q.alu_src;
    assign IDEXaluOp    = idex_q.alu_op;
    assign IDEXvalid    = idex_q.valid;
    assign stallCnt     = cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
module tb_idex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  IFIDrs, IFIDrt, IFIDrd, IFIDaluOp, MEMWBrd;
  logic        IFIDusesRt, IFIDregWrite, IFIDmemRead, IFIDmemWrite, IFIDaluSrc, IFIDvalid;
  logic [15:0] IFIDrdata1, IFIDrdata2, IFIDimm, MEMWBdata;
  logic        MEMWBregWrite, flush, memHold;

  logic [3:0]  IDEXrs, IDEXrt, IDEXrd, IDEXaluOp;
  logic [15:0] IDEXrdata1, IDEXrdata2, IDEXimm;
  logic        IDEXregWrite, IDEXmemRead, IDEXmemWrite, IDEXaluSrc, IDEXvalid, stallIF;
  logic [15:0] stallCnt;

  // Second instance with a narrow counter so saturation is reachable quickly.
  logic [3:0]  s_rs, s_rt, s_rd, s_aluOp;
  logic [15:0] s_rdata1, s_rdata2, s_imm;
  logic        s_regWrite, s_memRead, s_memWrite, s_aluSrc, s_valid, s_stallIF;
  logic [7:0]  s_cnt;

  int n_chk = 0;
  int n_pass = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  idex_stage dut (
    .clk(clk), .rst(rst),
    .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .IFIDrd(IFIDrd), .IFIDusesRt(IFIDusesRt),
    .IFIDrdata1(IFIDrdata1), .IFIDrdata2(IFIDrdata2), .IFIDimm(IFIDimm),
    .IFIDregWrite(IFIDregWrite), .IFIDmemRead(IFIDmemRead), .IFIDmemWrite(IFIDmemWrite),
    .IFIDaluSrc(IFIDaluSrc), .IFIDaluOp(IFIDaluOp), .IFIDvalid(IFIDvalid),
    .MEMWBregWrite(MEMWBregWrite), .MEMWBrd(MEMWBrd), .MEMWBdata(MEMWBdata),
    .flush(flush), .memHold(memHold),
    .IDEXrs(IDEXrs), .IDEXrt(IDEXrt), .IDEXrd(IDEXrd),
    .IDEXrdata1(IDEXrdata1), .IDEXrdata2(IDEXrdata2), .IDEXimm(IDEXimm),
    .IDEXregWrite(IDEXregWrite), .IDEXmemRead(IDEXmemRead), .IDEXmemWrite(IDEXmemWrite),
    .IDEXaluSrc(IDEXaluSrc), .IDEXvalid(IDEXvalid), .IDEXaluOp(IDEXaluOp),
    .stallIF(stallIF), .stallCnt(stallCnt)
  );

  idex_stage #(.CNT_W(8)) dut_sat (
    .clk(clk), .rst(rst),
    .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .IFIDrd(IFIDrd), .IFIDusesRt(IFIDusesRt),
    .IFIDrdata1(IFIDrdata1), .IFIDrdata2(IFIDrdata2), .IFIDimm(IFIDimm),
    .IFIDregWrite(IFIDregWrite), .IFIDmemRead(IFIDmemRead), .IFIDmemWrite(IFIDmemWrite),
    .IFIDaluSrc(IFIDaluSrc), .IFIDaluOp(IFIDaluOp), .IFIDvalid(IFIDvalid),
    .MEMWBregWrite(MEMWBregWrite), .MEMWBrd(MEMWBrd), .MEMWBdata(MEMWBdata),
    .flush(flush), .memHold(memHold),
    .IDEXrs(s_rs), .IDEXrt(s_rt), .IDEXrd(s_rd),
    .IDEXrdata1(s_rdata1), .IDEXrdata2(s_rdata2), .IDEXimm(s_imm),
    .IDEXregWrite(s_regWrite), .IDEXmemRead(s_memRead), .IDEXmemWrite(s_memWrite),
    .IDEXaluSrc(s_aluSrc), .IDEXvalid(s_valid), .IDEXaluOp(s_aluOp),
    .stallIF(s_stallIF), .stallCnt(s_cnt)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0]  rs, rt, rd;
    logic [15:0] d1, d2, imm;
    logic        rw, mr, mw, as;
    logic [3:0]  op;
    logic        v;
  } m_t;

  m_t m;
  int unsigned n_stalls;

  function automatic bit m_haz();
    if (!(m.v && m.mr && m.rt != 4'd0 && IFIDvalid)) return 1'b0;
    return (m.rt == IFIDrs) || (IFIDusesRt && m.rt == IFIDrt);
  endfunction

  function automatic bit m_stall_if();
    return memHold || (!flush && m_haz());
  endfunction

  function automatic logic [15:0] m_rdata(input logic [3:0] a, input logic [15:0] rf);
    return (MEMWBregWrite && MEMWBrd != 4'd0 && MEMWBrd == a) ? MEMWBdata : rf;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m = '0;
      n_stalls = 0;
    end else if (memHold) begin
      // frozen
    end else if (flush) begin
      m = '0;
    end else if (m_haz()) begin
      m = '0;
      n_stalls++;
    end else begin
      m = '{rs: IFIDrs, rt: IFIDrt, rd: IFIDrd,
            d1: m_rdata(IFIDrs, IFIDrdata1), d2: m_rdata(IFIDrt, IFIDrdata2),
            imm: IFIDimm, rw: IFIDregWrite, mr: IFIDmemRead, mw: IFIDmemWrite,
            as: IFIDaluSrc, op: IFIDaluOp, v: IFIDvalid};
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("rs", IDEXrs, m.rs);
    chk("rt", IDEXrt, m.rt);
    chk("rd", IDEXrd, m.rd);
    chk("rdata1", IDEXrdata1, m.d1);
    chk("rdata2", IDEXrdata2, m.d2);
    chk("imm", IDEXimm, m.imm);
    chk("regWrite", IDEXregWrite, m.rw);
    chk("memRead", IDEXmemRead, m.mr);
    chk("memWrite", IDEXmemWrite, m.mw);
    chk("aluSrc", IDEXaluSrc, m.as);
    chk("aluOp", IDEXaluOp, m.op);
    chk("valid", IDEXvalid, m.v);
    chk("stallIF", stallIF, m_stall_if());
    chk("stallCnt", stallCnt, (n_stalls > 65535) ? 65535 : n_stalls);
    chk("sat_valid", s_valid, m.v);
    chk("sat_stallIF", s_stallIF, m_stall_if());
    chk("sat_cnt", s_cnt, (n_stalls > 255) ? 255 : n_stalls);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                           input logic uses_rt, input logic mem_read);
    IFIDrs = rs; IFIDrt = rt; IFIDrd = rd; IFIDusesRt = uses_rt;
    IFIDmemRead = mem_read; IFIDregWrite = 1'b1; IFIDmemWrite = 1'b0;
    IFIDaluSrc = mem_read; IFIDaluOp = 4'd2; IFIDvalid = 1'b1;
    IFIDrdata1 = 16'h1234; IFIDrdata2 = 16'h5678; IFIDimm = 16'h0004;
  endtask

  task automatic rand_inputs();
    IFIDrs = 4'($urandom_range(0, 3)); IFIDrt = 4'($urandom_range(0, 3));
    IFIDrd = 4'($urandom_range(0, 15)); IFIDusesRt = 1'($urandom_range(0, 1));
    IFIDrdata1 = 16'($urandom); IFIDrdata2 = 16'($urandom); IFIDimm = 16'($urandom);
    IFIDregWrite = 1'($urandom_range(0, 1)); IFIDmemRead = 1'($urandom_range(0, 1));
    IFIDmemWrite = 1'($urandom_range(0, 1)); IFIDaluSrc = 1'($urandom_range(0, 1));
    IFIDaluOp = 4'($urandom); IFIDvalid = ($urandom_range(0, 7) != 0);
    MEMWBregWrite = 1'($urandom_range(0, 1)); MEMWBrd = 4'($urandom_range(0, 3));
    MEMWBdata = 16'($urandom);
    flush = ($urandom_range(0, 7) == 0); memHold = ($urandom_range(0, 7) == 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b1;
    IFIDrs = '0; IFIDrt = '0; IFIDrd = '0; IFIDusesRt = 0;
    IFIDrdata1 = '0; IFIDrdata2 = '0; IFIDimm = '0;
    IFIDregWrite = 0; IFIDmemRead = 0; IFIDmemWrite = 0; IFIDaluSrc = 0;
    IFIDaluOp = '0; IFIDvalid = 0;
    MEMWBregWrite = 0; MEMWBrd = '0; MEMWBdata = '0; flush = 0; memHold = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_valid", IDEXvalid, 0);
    chk("reset_cnt", stallCnt, 0);
    chk("reset_stallIF", stallIF, 0);

    // load-use: load writes r3, next instruction reads r3
    set_instr(4'd1, 4'd3, 4'd0, 1'b0, 1'b1);
    tick();
    set_instr(4'd3, 4'd4, 4'd5, 1'b1, 1'b0);
    #1 chk("lu_stallIF", stallIF, 1);
    tick();
    chk("lu_bubble", IDEXvalid, 0);
    chk("lu_cnt", stallCnt, 1);
    chk("lu_release", stallIF, 0);
    tick();
    chk("lu_adv_rs", IDEXrs, 3);
    chk("lu_adv_valid", IDEXvalid, 1);

    // no false hazard through r0 or an unused rt
    set_instr(4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    tick();
    set_instr(4'd0, 4'd0, 4'd6, 1'b1, 1'b0);
    #1 chk("r0_no_haz", stallIF, 0);
    set_instr(4'd1, 4'd5, 4'd0, 1'b0, 1'b1);
    tick();
    set_instr(4'd1, 4'd5, 4'd6, 1'b0, 1'b0);
    #1 chk("rt_unused_no_haz", stallIF, 0);
    IFIDusesRt = 1'b1;
    #1 chk("rt_used_haz", stallIF, 1);
    IFIDusesRt = 1'b0;

    // WB bypass on both operands, then suppressed for r0 destination
    set_instr(4'd7, 4'd7, 4'd8, 1'b1, 1'b0);
    IFIDrdata1 = 16'h1111; IFIDrdata2 = 16'h1111;
    MEMWBregWrite = 1'b1; MEMWBrd = 4'd7; MEMWBdata = 16'hBEEF;
    tick();
    chk("byp_rdata1", IDEXrdata1, 16'hBEEF);
    chk("byp_rdata2", IDEXrdata2, 16'hBEEF);
    MEMWBrd = 4'd0;
    tick();
    chk("nobyp_rdata1", IDEXrdata1, 16'h1111);
    chk("nobyp_rdata2", IDEXrdata2, 16'h1111);
    MEMWBregWrite = 1'b0;

    // flush beats load-use
    set_instr(4'd1, 4'd3, 4'd0, 1'b0, 1'b1);
    tick();
    set_instr(4'd3, 4'd4, 4'd5, 1'b1, 1'b0);
    flush = 1'b1;
    #1 chk("pri_flush_stallIF", stallIF, 0);
    tick();
    chk("pri_flush_bubble", IDEXvalid, 0);
    chk("pri_flush_cnt", stallCnt, 1);
    flush = 1'b0;
    set_instr(4'd1, 4'd2, 4'd9, 1'b1, 1'b0);
    tick();
    // hold beats flush for three cycles, flush lands once hold drops
    memHold = 1'b1; flush = 1'b1;
    repeat (3) begin
      #1 chk("hold_stallIF", stallIF, 1);
      tick();
      chk("hold_rd", IDEXrd, 9);
      chk("hold_valid", IDEXvalid, 1);
    end
    memHold = 1'b0;
    #1 chk("unhold_stallIF", stallIF, 0);
    tick();
    chk("unhold_bubble", IDEXvalid, 0);
    flush = 1'b0;

    // back-to-back load-use stalls: 300 more, narrow counter saturates
    set_instr(4'd3, 4'd3, 4'd0, 1'b1, 1'b1);
    repeat (600) tick();
    chk("sat_cnt_ff", s_cnt, 8'hFF);
    chk("cnt_301", stallCnt, 301);

    // randomized traffic against the model
    repeat (2000) begin
      rand_inputs();
      tick();
    end
    flush = 1'b0; memHold = 1'b0;

    // reset in the middle of a load-use stall
    set_instr(4'd1, 4'd3, 4'd0, 1'b0, 1'b1);
    tick();
    set_instr(4'd3, 4'd4, 4'd5, 1'b1, 1'b0);
    #1 chk("pre_rst_stallIF", stallIF, 1);
    rst = 1'b1;
    #1;
    chk("rst_valid", IDEXvalid, 0);
    chk("rst_memRead", IDEXmemRead, 0);
    chk("rst_rt", IDEXrt, 0);
    chk("rst_cnt", stallCnt, 0);
    chk("rst_stallIF", stallIF, 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline register with integrated load-use hazard detection and write-back bypass for the 16-register, 16-bit pipelined core. Captures decoded operands and control from the ID stage each cycle, inserts bubbles on load-use hazards and branch flushes, and freezes on memory hold. Its IDEX* outputs drive the EX stage and the forwarding unit directly.

## Interface
- DATA_W, 16, operand/immediate width
- REG_W, 4, register address width (register 0 is hard-wired zero)
- CNT_W, 16, stall counter width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- IFIDrs, IFIDrt, IFIDrd  in  REG_W  decoded source/destination addresses
- IFIDusesRt  in  1  instruction reads rt as an operand
- IFIDrdata1, IFIDrdata2  in  DATA_W  register file read data for rs/rt
- IFIDimm  in  DATA_W  sign-extended immediate
- IFIDregWrite, IFIDmemRead, IFIDmemWrite, IFIDaluSrc  in  1  decoded control
- IFIDaluOp  in  4  ALU operation
- IFIDvalid  in  1  ID holds a real instruction
- MEMWBregWrite  in  1  WB writes register file this cycle
- MEMWBrd  in  REG_W  WB destination
- MEMWBdata  in  DATA_W  WB write data
- flush  in  1  taken branch/jump resolved in EX
- memHold  in  1  data memory busy; whole pipe frozen
- IDEXrs, IDEXrt, IDEXrd  out  REG_W  registered addresses
- IDEXrdata1, IDEXrdata2, IDEXimm  out  DATA_W  registered operands
- IDEXregWrite, IDEXmemRead, IDEXmemWrite, IDEXaluSrc, IDEXvalid  out  1  registered control
- IDEXaluOp  out  4  registered ALU op
- stallIF  out  1  combinational; hold PC and IF/ID register
- stallCnt  out  CNT_W  saturating count of load-use bubbles inserted

## Operation
- Load-use hazard (comb.): luHaz = IDEXvalid & IDEXmemRead & (IDEXrt != 0) & IFIDvalid & ((IDEXrt == IFIDrs) | (IFIDusesRt & IDEXrt == IFIDrt)).
- Per-cycle action, priority highest first:
  - HOLD (memHold=1): all IDEX registers and stallCnt retain; stallIF=1.
  - FLUSH (flush=1): load bubble; stallIF=0; luHaz ignored; stallCnt unchanged.
  - STALL (luHaz=1): load bubble; stallIF=1; stallCnt += 1, saturating at all-ones.
  - RUN: load all IFID* fields into IDEX*; stallIF=0.
- Bubble: IDEXvalid, IDEXregWrite, IDEXmemRead, IDEXmemWrite, IDEXaluSrc = 0; IDEXaluOp = 0; addresses, data, and immediate = 0.
- WB bypass (RUN only): if MEMWBregWrite & (MEMWBrd != 0) & (MEMWBrd == IFIDrs), IDEXrdata1 captures MEMWBdata instead of IFIDrdata1. The same rule applies independently to rt/IDEXrdata2. The bypass is not gated by IFIDusesRt.
- IFIDvalid=0 in RUN: all fields load as given, with no masking. Downstream treats IDEXvalid=0 as NOP.
- Register 0 is never a hazard or bypass source.
- Load-use stall lasts exactly one cycle. The next cycle IDEX holds a bubble (IDEXmemRead=0), so luHaz deasserts and the held instruction advances.

## Timing
- Reset (async assert, sync release on next edge): all IDEX* outputs = 0, stallCnt = 0, hence stallIF = 0.
- Latency: IFID inputs appear on IDEX outputs 1 cycle after the capturing edge.
- stallIF is combinational from current IDEX state plus IFID/flush/memHold inputs. It is valid within the same cycle, with no registered delay.
- flush and luHaz in the same cycle: FLUSH wins; stallIF=0; stallCnt unchanged.
- memHold with flush or luHaz: HOLD wins. Both are re-evaluated when memHold drops, so flush must be held by its source until memHold is released.
- Reset mid-stall: outputs clear immediately; stallIF drops as IDEXmemRead becomes 0.
- stallCnt at 0xFFFF plus another stall: stays 0xFFFF.

## Test plan
- Reset: assert rst mid-cycle with IDEX loaded -> all outputs 0 asynchronously; stallIF=0; stallCnt=0.
- Load-use: cycle n IDEX = load (memRead=1, rt=3); IFID = add rs=3 -> stallIF=1 in n; IDEXvalid=0 at n+1; add appears in IDEX at n+2 with rs=3; stallCnt=1.
- No false hazard: load rt=0 followed by rs=0 -> stallIF=0. Load rt=5 followed by IFIDrt=5 with IFIDusesRt=0 -> stallIF=0.
- WB bypass: MEMWBregWrite=1, MEMWBrd=7, MEMWBdata=0xBEEF, IFIDrs=7, IFIDrt=7, rdata=0x1111 -> IDEXrdata1 = IDEXrdata2 = 0xBEEF next cycle. With MEMWBrd=0 -> both 0x1111.
- Priority: luHaz and flush together -> bubble, stallIF=0, stallCnt unchanged. Then memHold=1 with flush=1 for 3 cycles -> IDEX frozen, stallIF=1, and the bubble loads on the first cycle after memHold=0.
- Saturation: force 65536 load-use stalls -> stallCnt = 0xFFFF and holds at 0xFFFF.
